// File: rtl/frame_output_fifo.sv
// Frame output buffer: body bytes and closing headers are queued separately,
// then emitted per frame as header bytes (LSB first) followed by the body.
module frame_output_fifo #(
   parameter int FRAME_SIZE = 16,
   parameter int BODY_DEPTH = 64,
   parameter int HDR_DEPTH  = 4,
   parameter int LEN_WIDTH  = 32
) (
   input  logic                  ClkxCI,
   input  logic                  RstxRI,
   input  logic [7:0]            BodyDataxDI,
   input  logic                  BodyStrobexSI,
   input  logic [FRAME_SIZE-1:0] HeaderDataxDI,
   input  logic                  HeaderStrobexSI,
   output logic [7:0]            BufOutxDO,
   output logic                  OutputValidxSO,
   input  logic                  RdStrobexSI,
   output logic                  BuffersEmptyxSO,
   output logic                  BodyFullxSO,
   output logic                  OverflowxSO,
   output logic [LEN_WIDTH-1:0]  LengthxDO
);

   localparam int BAW = $clog2(BODY_DEPTH);
   localparam int HAW = $clog2(HDR_DEPTH);
   localparam int CW  = $clog2(2 * FRAME_SIZE + 1);
   localparam int NB  = FRAME_SIZE / 8;
   localparam int HW  = FRAME_SIZE + CW;

   localparam logic [BAW:0] B_FULL   = (BAW + 1)'(BODY_DEPTH);
   localparam logic [BAW:0] B_ALMOST = (BAW + 1)'(BODY_DEPTH - 1);
   localparam logic [HAW:0] H_FULL   = (HAW + 1)'(HDR_DEPTH);
   localparam logic [CW-1:0] C_MAX   = CW'(2 * FRAME_SIZE);
   localparam logic [1:0] LAST_IDX   = 2'(NB - 1);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      BODY
   } state_t;

   state_t state, state_nxt;

   logic [7:0]    body_mem [BODY_DEPTH];
   logic [BAW:0]  body_wr, body_rd, body_cnt;
   logic [HW-1:0] hdr_mem [HDR_DEPTH];
   logic [HAW:0]  hdr_wr, hdr_rd, hdr_cnt;

   logic [CW-1:0] open_cnt, frame_cnt;
   logic [CW-1:0] remain, remain_nxt;
   logic [1:0]    idx, idx_nxt;

   logic          body_push, hdr_push;
   logic          body_pop, hdr_pop;
   logic          rd_ok, ovf_evt;
   logic          body_full_now, hdr_full_now, open_full;

   logic [HW-1:0] hdr_head;
   logic [31:0]   hdr_word;
   logic [CW-1:0] head_cnt;
   logic [7:0]    hdr_byte;

   assign body_cnt      = body_wr - body_rd;
   assign hdr_cnt       = hdr_wr - hdr_rd;
   assign body_full_now = (body_cnt == B_FULL);
   assign hdr_full_now  = (hdr_cnt == H_FULL);
   assign open_full     = (open_cnt == C_MAX);

   // Fullness is judged on current occupancy, so a same-cycle read never
   // makes room for a write.
   assign body_push = BodyStrobexSI & ~body_full_now & ~open_full;
   assign hdr_push  = HeaderStrobexSI & ~hdr_full_now;
   assign ovf_evt   = (BodyStrobexSI & ~body_push)
                    | (HeaderStrobexSI & ~hdr_push);

   assign frame_cnt = open_cnt + {{(CW-1){1'b0}}, body_push};

   assign hdr_head = hdr_mem[hdr_rd[HAW-1:0]];
   assign hdr_word = 32'(hdr_head[HW-1:CW]);
   assign head_cnt = hdr_head[CW-1:0];
   assign hdr_byte = hdr_word[{idx, 3'b000} +: 8];

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      remain_nxt = remain;
      hdr_pop    = 1'b0;
      body_pop   = 1'b0;
      unique case (state)
         IDLE: begin
            // A header arriving into an idle block is presented next cycle.
            if ((hdr_cnt != '0) || hdr_push) begin
               state_nxt = HDR;
               idx_nxt   = 2'd0;
            end
         end
         HDR: begin
            if (RdStrobexSI) begin
               if (idx == LAST_IDX) begin
                  if (head_cnt != '0) begin
                     state_nxt  = BODY;
                     remain_nxt = head_cnt;
                  end else begin
                     hdr_pop   = 1'b1;
                     state_nxt = IDLE;
                  end
               end else begin
                  idx_nxt = idx + 2'd1;
               end
            end
         end
         BODY: begin
            if (RdStrobexSI) begin
               body_pop   = 1'b1;
               remain_nxt = remain - CW'(1);
               if (remain == CW'(1)) begin
                  hdr_pop   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_ok          = RdStrobexSI & (state != IDLE);
   assign OutputValidxSO = (state != IDLE);

   always_comb begin
      BufOutxDO = 8'h00;
      if (state == HDR) begin
         BufOutxDO = hdr_byte;
      end else if (state == BODY) begin
         BufOutxDO = body_mem[body_rd[BAW-1:0]];
      end
   end

   assign BuffersEmptyxSO = (body_cnt == '0) & (hdr_cnt == '0)
                          & (open_cnt == '0) & (state == IDLE);
   assign BodyFullxSO     = (body_cnt >= B_ALMOST);

   always_ff @(posedge ClkxCI) begin
      if (body_push) begin
         body_mem[body_wr[BAW-1:0]] <= BodyDataxDI;
      end
      if (hdr_push) begin
         hdr_mem[hdr_wr[HAW-1:0]] <= {HeaderDataxDI, frame_cnt};
      end
   end

   always_ff @(posedge ClkxCI or posedge RstxRI) begin
      if (RstxRI) begin
         body_wr     <= '0;
         body_rd     <= '0;
         hdr_wr      <= '0;
         hdr_rd      <= '0;
         open_cnt    <= '0;
         state       <= IDLE;
         idx         <= 2'd0;
         remain      <= '0;
         LengthxDO   <= '0;
         OverflowxSO <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         remain <= remain_nxt;
         if (body_push) begin
            body_wr <= body_wr + (BAW + 1)'(1);
         end
         if (body_pop) begin
            body_rd <= body_rd + (BAW + 1)'(1);
         end
         if (hdr_push) begin
            hdr_wr <= hdr_wr + (HAW + 1)'(1);
         end
         if (hdr_pop) begin
            hdr_rd <= hdr_rd + (HAW + 1)'(1);
         end
         if (HeaderStrobexSI) begin
            open_cnt <= '0;
         end else if (body_push) begin
            open_cnt <= open_cnt + CW'(1);
         end
         if (rd_ok) begin
            LengthxDO <= LengthxDO + LEN_WIDTH'(1);
         end
         if (ovf_evt) begin
            OverflowxSO <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_output_fifo.sv
// Scoreboard bench for frame_output_fifo: directed frames, expected bytes
// queued at stimulus time and checked by an independent output monitor.
module tb_frame_output_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  bdata;
   logic        bstb;
   logic [15:0] hdata;
   logic        hstb;
   logic [7:0]  bout;
   logic        ovalid;
   logic        rd;
   logic        empty;
   logic        bfull;
   logic        ovf;
   logic [3:0]  len;

   int pass_n  = 0;
   int total_n = 0;
   logic [7:0] exp_q[$];

   frame_output_fifo #(
      .FRAME_SIZE(16),
      .BODY_DEPTH(64),
      .HDR_DEPTH (4),
      .LEN_WIDTH (4)
   ) dut (
      .ClkxCI         (clk),
      .RstxRI         (rst),
      .BodyDataxDI    (bdata),
      .BodyStrobexSI  (bstb),
      .HeaderDataxDI  (hdata),
      .HeaderStrobexSI(hstb),
      .BufOutxDO      (bout),
      .OutputValidxSO (ovalid),
      .RdStrobexSI    (rd),
      .BuffersEmptyxSO(empty),
      .BodyFullxSO    (bfull),
      .OverflowxSO    (ovf),
      .LengthxDO      (len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      total_n++;
      if (act == req) pass_n++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
   endtask

   // Monitor: a byte is consumed when valid and read meet at the next edge.
   always @(negedge clk) begin
      if (!rst && ovalid && rd) begin
         if (exp_q.size() == 0) begin
            total_n++;
            $display("FAIL out_extra: got 0x%0h expected none", bout);
         end else begin
            chk("out_byte", int'(bout), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic exp_hdr(input logic [15:0] h);
      exp_q.push_back(h[7:0]);
      exp_q.push_back(h[15:8]);
   endtask

   task automatic body(input logic [7:0] b);
      bdata = b;
      bstb  = 1'b1;
      @(posedge clk); #1;
      bstb  = 1'b0;
   endtask

   task automatic header(input logic [15:0] h, input bit wb,
                         input logic [7:0] b);
      hdata = h;
      hstb  = 1'b1;
      if (wb) begin
         bdata = b;
         bstb  = 1'b1;
      end
      @(posedge clk); #1;
      hstb = 1'b0;
      bstb = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      rd = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0 && empty) begin
            done = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      rd = 1'b0;
      chk("drain_done", int'(done), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; bstb = 1'b0; hstb = 1'b0;
      rd = 1'b0; bdata = 8'h00; hdata = 16'h0000;
      repeat (2) @(posedge clk); #1;
      chk("rst_valid", int'(ovalid), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(bfull), 0);
      chk("rst_out", int'(bout), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_len", int'(len), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // basic frame, read held high
      rd = 1'b1;
      exp_hdr(16'h1234);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hA2);
      exp_q.push_back(8'hA3);
      body(8'hA1);
      body(8'hA2);
      body(8'hA3);
      header(16'h1234, 1'b0, 8'h00);
      chk("lat_valid", int'(ovalid), 1);
      drain();
      chk("len_5", int'(len), 5);
      chk("empty_5", int'(empty), 1);

      // empty frame, then header with same-cycle body
      rd = 1'b0;
      exp_hdr(16'hBEEF);
      exp_hdr(16'h0001);
      exp_q.push_back(8'h55);
      header(16'hBEEF, 1'b0, 8'h00);
      chk("lat2_valid", int'(ovalid), 1);
      chk("lat2_out", int'(bout), 'hEF);
      header(16'h0001, 1'b1, 8'h55);
      chk("hold_out", int'(bout), 'hEF);
      drain();
      chk("len_10", int'(len), 10);

      // reads while nothing is valid
      for (int i = 0; i < 10; i++) begin
         rd = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk("idle_valid", int'(ovalid), 0);
      end
      rd = 1'b0;
      chk("idle_len", int'(len), 10);

      // body overflow: 96 bodies into a 64 entry FIFO
      exp_hdr(16'hC001);
      for (int k = 0; k < 32; k++) exp_q.push_back(8'(k));
      exp_hdr(16'hC002);
      for (int k = 32; k < 64; k++) exp_q.push_back(8'(k));
      exp_hdr(16'hC003);
      for (int k = 0; k < 96; k++) begin
         body(8'(k));
         if (k == 60) chk("full_61", int'(bfull), 0);
         if (k == 62) chk("full_63", int'(bfull), 1);
         if (k == 63) chk("ovf_64", int'(ovf), 0);
         if (k == 64) chk("ovf_65", int'(ovf), 1);
         if (k == 31) header(16'hC001, 1'b0, 8'h00);
         if (k == 63) header(16'hC002, 1'b0, 8'h00);
         if (k == 95) header(16'hC003, 1'b0, 8'h00);
      end
      drain();
      chk("len_80", int'(len), 0);
      chk("ovf_sticky", int'(ovf), 1);

      // reset in the middle of a frame body
      exp_hdr(16'hAAAA);
      for (int k = 16; k < 20; k++) exp_q.push_back(8'(k));
      for (int k = 16; k < 20; k++) body(8'(k));
      header(16'hAAAA, 1'b0, 8'h00);
      rd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rd = 1'b0;
      chk("mid_valid", int'(ovalid), 1);
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("arst_valid", int'(ovalid), 0);
      chk("arst_len", int'(len), 0);
      chk("arst_out", int'(bout), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post_ovf", int'(ovf), 0);
      chk("post_empty", int'(empty), 1);
      exp_hdr(16'h0000);
      exp_q.push_back(8'h7E);
      body(8'h7E);
      header(16'h0000, 1'b0, 8'h00);
      drain();
      chk("len_3", int'(len), 3);

      // header queue overflow
      for (int i = 1; i <= 4; i++) exp_hdr(16'(i * 16'h1111));
      for (int i = 1; i <= 5; i++) begin
         header(16'(i * 16'h1111), 1'b0, 8'h00);
         if (i == 4) chk("hovf_4", int'(ovf), 0);
         if (i == 5) chk("hovf_5", int'(ovf), 1);
      end
      drain();
      chk("len_11", int'(len), 11);

      // length counter wraps at 16
      exp_hdr(16'h00FF);
      for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
      for (int k = 1; k <= 4; k++) body(8'(k));
      header(16'h00FF, 1'b0, 8'h00);
      drain();
      chk("len_wrap", int'(len), 1);
      chk("end_empty", int'(empty), 1);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
